// File: rtl/mpu_operand_skewer.sv
// Operand skewer feeding the NxN int8 systolic array.
// Accepts one k-beat (A column, B row) per handshake, skews lane i by i+2
// register stages, and sequences acc clear / drain / result_valid per job.

// One skew lane: DEPTH-deep shift register; zeros enter on idle cycles.
module mpu_skew_lane #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [DEPTH-1:0][W-1:0] sr;

  // Shift the lane one stage per clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int s = 1; s < DEPTH; s++) sr[s] <= sr[s-1];
    end
  end

  assign q = sr[DEPTH-1];
endmodule

module mpu_operand_skewer #(
  parameter  int N     = 8,
  parameter  int DW    = 8,
  parameter  int K_MAX = 8,
  localparam int KW    = $clog2(K_MAX+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [N-1:0][DW-1:0] in_a,
  input  logic [N-1:0][DW-1:0] in_b,
  output logic [N-1:0][DW-1:0] a_out,
  output logic [N-1:0][DW-1:0] b_out,
  output logic                 acc_clr,
  output logic                 busy,
  output logic                 result_valid,
  output logic [KW-1:0]        k_cnt
);
  // Drain covers lane N-1 skew, N-1 PE hops and the final accumulate.
  localparam int DCW = $clog2(2*N+2);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(2*N+1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [DCW-1:0]             dcnt_q, dcnt_d;
  logic [KW-1:0]              k_d, k_inc;
  logic                       clr_d;
  logic                       accept;
  logic [N-1:0][2*DW-1:0]     lane_d, lane_q;

  assign in_ready     = rst && (state_q != DRAIN);
  assign accept       = in_valid && in_ready;
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DRAIN) && (dcnt_q == '0);
  assign k_inc        = k_cnt + KW'(1);

  // Accepted beats enter the lanes; anything else injects a zero bubble.
  always_comb begin
    lane_d = '0;
    for (int i = 0; i < N; i++)
      if (accept) lane_d[i] = {in_a[i], in_b[i]};
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      mpu_skew_lane #(.W(2*DW), .DEPTH(gi+2)) u_lane (
        .clk (clk),
        .rst (rst),
        .d   (lane_d[gi]),
        .q   (lane_q[gi])
      );
      assign a_out[gi] = lane_q[gi][2*DW-1:DW];
      assign b_out[gi] = lane_q[gi][DW-1:0];
    end
  endgenerate

  // Job sequencing: next state, drain counter, beat count, clear pulse.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    k_d     = k_cnt;
    clr_d   = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        k_d   = KW'(1);
        clr_d = 1'b1;
        if (in_last || (K_MAX == 1)) begin
          state_d = DRAIN;
          dcnt_d  = DRAIN_LOAD;
        end else begin
          state_d = STREAM;
        end
      end
      STREAM: if (accept) begin
        k_d = k_inc;
        if (in_last || (k_inc == KW'(K_MAX))) begin
          state_d = DRAIN;
          dcnt_d  = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (dcnt_q == '0) state_d = IDLE;
        else              dcnt_d  = dcnt_q - DCW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      k_cnt   <= '0;
      acc_clr <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      k_cnt   <= k_d;
      acc_clr <= clr_d;
    end
  end
endmodule

// File: tb/tb_mpu_operand_skewer.sv
// Randomized + directed bench for mpu_operand_skewer with a per-edge
// reference model (beat history by edge index) and a negedge scoreboard.
module tb_mpu_operand_skewer;
  localparam int N     = 8;
  localparam int DW    = 8;
  localparam int K_MAX = 8;
  localparam int KW    = $clog2(K_MAX+1);
  localparam int NONE  = -1000;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct packed {
    vec_t          a;
    vec_t          b;
    logic          clr;
    logic          rv;
    logic          busy;
    logic          rdy;
    logic [KW-1:0] k;
  } exp_t;

  bit            clk;
  logic          rst, in_valid, in_last, in_ready;
  logic          acc_clr, busy, result_valid;
  vec_t          in_a, in_b, a_out, b_out;
  logic [KW-1:0] k_cnt;

  int   checks, errors;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  mpu_operand_skewer #(.N(N), .DW(DW), .K_MAX(K_MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_last      (in_last),
    .in_a         (in_a),
    .in_b         (in_b),
    .a_out        (a_out),
    .b_out        (b_out),
    .acc_clr      (acc_clr),
    .busy         (busy),
    .result_valid (result_valid),
    .k_cnt        (k_cnt)
  );

  // Reference model: what was accepted on each edge, plus job bookkeeping.
  int   t;
  vec_t ha [int];
  vec_t hb [int];
  bit   in_job, acc_flag;
  int   kc, clr_edge, l_last;

  function automatic void model_reset();
    ha.delete(); hb.delete();
    in_job = 0; kc = 0; clr_edge = NONE; l_last = NONE;
  endfunction

  function automatic void model_edge();
    bit drain;
    t++;
    acc_flag = 0;
    if (!rst) begin
      model_reset();
      return;
    end
    drain    = (t > l_last) && (t <= l_last + 2*N + 2);
    acc_flag = in_valid && !drain;
    if (acc_flag) begin
      ha[t] = in_a;
      hb[t] = in_b;
      if (!in_job) begin
        in_job = 1; kc = 1; clr_edge = t;
      end else begin
        kc++;
      end
      if (in_last || kc == K_MAX) begin
        l_last = t;
        in_job = 0;
      end
    end
  endfunction

  // Expected outputs in the interval following edge t.
  function automatic exp_t predict();
    exp_t e;
    vec_t va, vb;
    bit   drain_after;
    e = '0;
    for (int i = 0; i < N; i++) begin
      if (ha.exists(t-1-i)) begin
        va = ha[t-1-i];
        vb = hb[t-1-i];
        e.a[i] = va[i];
        e.b[i] = vb[i];
      end
    end
    drain_after = (t >= l_last) && (t < l_last + 2*N + 2);
    e.clr  = (clr_edge == t);
    e.rv   = (l_last + 2*N + 1 == t);
    e.busy = in_job || drain_after;
    e.rdy  = rst && !drain_after;
    e.k    = KW'(kc);
    return e;
  endfunction

  function automatic void chk(string name, logic [N*DW-1:0] act, logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%h expected=%h", name, t, act, exp);
    end
  endfunction

  // Scoreboard monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("a_out",        a_out,        mon_e.a);
      chk("b_out",        b_out,        mon_e.b);
      chk("acc_clr",      {63'd0, acc_clr},      {63'd0, mon_e.clr});
      chk("result_valid", {63'd0, result_valid}, {63'd0, mon_e.rv});
      chk("busy",         {63'd0, busy},         {63'd0, mon_e.busy});
      chk("in_ready",     {63'd0, in_ready},     {63'd0, mon_e.rdy});
      chk("k_cnt",        {60'd0, k_cnt},        {60'd0, mon_e.k});
    end
  end

  function automatic vec_t rvec();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = DW'($urandom);
    return v;
  endfunction

  function automatic vec_t mk3(int x, int y, int z);
    vec_t v;
    v = '0;
    v[0] = DW'(x); v[1] = DW'(y); v[2] = DW'(z);
    return v;
  endfunction

  // Drive inputs for the next edge, queue the expectation, advance one edge.
  task automatic cyc(input logic v, input logic l, input vec_t a, input vec_t b, input logic r);
    in_valid = v; in_last = l; in_a = a; in_b = b; rst = r;
    if (!r) model_reset();
    exp_q.push_back(predict());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, rvec(), rvec(), 1'b1);
  endtask

  // Present a beat and hold it until accepted (bounded).
  task automatic send(input vec_t a, input vec_t b, input logic l);
    int g;
    g = 0;
    do begin
      cyc(1'b1, l, a, b, 1'b1);
      g++;
    end while (!acc_flag && g < 100);
    checks++;
    if (!acc_flag) begin
      errors++;
      $display("FAIL send_timeout edge=%0d actual=not_accepted expected=accepted", t);
    end
  endtask

  task automatic job3();
    send(mk3(1,2,3), mk3(10,13,16), 1'b0);
    send(mk3(4,5,6), mk3(11,14,17), 1'b0);
    send(mk3(7,8,9), mk3(12,15,18), 1'b1);
  endtask

  initial begin
    checks = 0; errors = 0; t = 0;
    model_reset();
    rst = 1'b0; in_valid = 1'b1; in_last = 1'b0; in_a = '0; in_b = '0;
    @(posedge clk); #1;

    // Reset held with live traffic on the inputs.
    repeat (4) cyc(1'b1, 1'b0, rvec(), rvec(), 1'b0);
    idle(2);

    // Directed 3-beat job.
    job3();
    idle(22);

    // Bubble between beats 1 and 2.
    send(mk3(1,2,3), mk3(10,13,16), 1'b0);
    idle(1);
    send(mk3(4,5,6), mk3(11,14,17), 1'b0);
    send(mk3(7,8,9), mk3(12,15,18), 1'b1);
    idle(22);

    // K_MAX overrun with in_last never asserted.
    repeat (K_MAX) send('1, '1, 1'b0);
    idle(22);

    // Single-beat job, next beat held through DRAIN, then back-to-back.
    send(mk3(5,6,7), mk3(8,9,10), 1'b1);
    send(mk3(11,12,13), mk3(14,15,16), 1'b1);
    idle(22);

    // Reset two cycles into DRAIN, then a fresh job.
    send(mk3(21,22,23), mk3(24,25,26), 1'b1);
    idle(2);
    repeat (2) cyc(1'b1, 1'b0, rvec(), rvec(), 1'b0);
    idle(3);
    job3();
    idle(22);

    // Randomized jobs with bubbles, back-to-back starts and rare resets.
    repeat (60) begin
      int nb;
      nb = $urandom_range(1, 10);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send(rvec(), rvec(), (b == nb-1) ? 1'b1 : 1'b0);
      end
      if ($urandom_range(0, 29) == 0) begin
        idle($urandom_range(0, 6));
        cyc(1'b1, 1'b0, rvec(), rvec(), 1'b0);
      end
      idle($urandom_range(0, 3));
    end
    idle(22);

    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mpu_operand_skewer.md
Name: mpu_operand_skewer

Overview:
- Feeder stage directly upstream of the 8x8 int8 systolic `buffer` array.
- Accepts one k-beat per handshake: column k of A (one element per array row) and row k of B (one element per array column).
- Emits the diagonally skewed a/b lane vectors the array consumes, with zeros used as bubbles.
- Sequences each matrix job: accumulator clear at start, pipeline drain after the last beat, `result_valid` when `c` is final.

Parameters:
- N, 8, array dimension; lane count for a and b.
- DW, 8, operand width.
- K_MAX, 8, maximum k-beats per job; reaching it forces end of stream.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  skewer can accept a beat.
- in_last  in  1  qualifies the final beat of the job.
- in_a  in  N x DW  A column k; in_a[i] = A[i][k].
- in_b  in  N x DW  B row k; in_b[j] = B[k][j].
- a_out  out  N x DW  to array a[0:N-1].
- b_out  out  N x DW  to array b[0:N-1].
- acc_clr  out  1  one-cycle accumulator clear to the array.
- busy  out  1  job in progress (STREAM or DRAIN).
- result_valid  out  1  one-cycle pulse; array c outputs are final.
- k_cnt  out  $clog2(K_MAX+1)  beats accepted in the current job.

Behaviour:
- Reset (rst=0, async): all delay registers 0; a_out=b_out=0; acc_clr=0; result_valid=0; busy=0; k_cnt=0; state IDLE. in_ready=1 after release.
- Transfer: a beat is accepted when in_valid && in_ready at a rising edge.
- FSM states:
  - IDLE: in_ready=1. Accepting a beat → STREAM; acc_clr=1 next cycle only; k_cnt=1.
  - STREAM: in_ready=1. Each accepted beat increments k_cnt.
    - Accepted beat with in_last=1, or accepted beat making k_cnt==K_MAX → DRAIN; load drain counter with 2N+1.
    - in_valid=0 cycles inject a zero beat into all lanes and leave state unchanged.
  - DRAIN: in_ready=0. Zero beats are injected and the counter decrements each cycle. When the counter reaches 0 → IDLE, and result_valid=1 for exactly that one cycle.
- Skew and latency:
  - Lane i of a_out and lane i of b_out present the beat accepted i+2 edges earlier.
  - Lane 0 is a 2-register pipe; lane N-1 is N+1 registers deep.
  - Non-accepting cycles shift 0 into every lane.
  - acc_clr (latency 1) is therefore high exactly one cycle before the first beat appears on lane 0.
- result_valid timing:
  - Follows the last-beat acceptance edge by exactly 2N+2 edges (2N+1 counter cycles plus the expiry cycle).
  - This covers the lane N-1 skew plus the N-1 PE hop plus one accumulate to PE(N-1,N-1).
- busy = 1 in STREAM or DRAIN.
- k_cnt holds its value through DRAIN; it resets to 1 on the next job's first beat.
- Boundary conditions:
  - Single-beat job (in_last on the first beat): IDLE → DRAIN directly, with acc_clr still pulsed.
  - in_last and k_cnt==K_MAX on the same beat: one DRAIN entry.
  - Beats presented during DRAIN are not accepted; the upstream must hold them.
  - A new job's first beat may be accepted the cycle after result_valid (IDLE).
- Reset mid-STREAM or mid-DRAIN: immediate clear of all lanes and counters; no result_valid; no acc_clr after release until a new first beat.
- No arithmetic: data is passed unmodified; DW bits per lane.

Test Plan:
- Reset: hold rst=0 with in_valid=1 and random data → all outputs 0, no beat accepted. Release → in_ready=1, busy=0.
- 3-beat job, N=8:
  - Stimulus:
    - in_a=(1,2,3,0..), (4,5,6,0..), (7,8,9,0..) on consecutive edges from E.
    - in_b=(10,13,16,0..), (11,14,17,0..), (12,15,18,0..).
    - in_last on beat 3.
  - Required response:
    - acc_clr high in cycle E+1.
    - a_out[0] = 1,4,7 in cycles E+2..E+4; a_out[1] = 2,5,8 in cycles E+3..E+5; a_out[2] = 3,6,9 in cycles E+4..E+6.
    - b_out follows the same pattern with 10..18.
    - Other lanes 0.
    - result_valid only in cycle (E+2)+2N+2 = E+20.
- Bubble: job as above with in_valid=0 for one cycle between beats 1 and 2 → every lane shows a 0 between 1 and 4 (a_out[0]=1,0,4,7). result_valid moves one cycle later. k_cnt=3.
- K_MAX overrun: 8 beats of all-ones with in_last never asserted → DRAIN after the 8th beat, in_ready=0 the next cycle, k_cnt=8, result_valid 2N+2 edges later.
- Backpressure and back-to-back:
  - A 1-beat job with in_valid held during DRAIN → in_ready=0 for 2N+2 cycles.
  - The next beat is accepted the cycle after result_valid, with a new acc_clr pulse.
- Mid-job reset: assert rst=0 two cycles into DRAIN → outputs 0 immediately and no result_valid. A fresh job after release behaves as in the 3-beat job case.
